seg7_row_streamer: RTL and testbench
====================================

Name: seg7_row_streamer

Overview:
- Renders a row of DIGITS seven-segment characters into an SSD1306 page-mode byte stream, one column byte at a time, under valid/ready flow control.
- Latches a packed hex/BCD value on start, decodes each digit to segments, and applies leading-zero blanking and decimal/hex mode.
- Drives an external combinational glyph lookup (segments + column/page index in, pixel byte out).
- Sits between the frequency-count formatter and the SSD1306 transfer engine.

Parameters:
DIGITS, 6, number of characters per row (1..16)
GLYPH_W, 21, glyph width in columns (2..32)
GAP_W, 3, blank columns emitted after each glyph (0..7)
PAGES, 4, 8-pixel pages per glyph height (1..8)

Ports:
clk_in  input  1  clock, rising edge
reset_n_in  input  1  asynchronous active-low reset
start_in  input  1  request render; accepted only when busy_out=0
digits_in  input  4*DIGITS  digit i (0 = leftmost) at bits [4*(DIGITS-i)-1 -: 4]
hex_mode_in  input  1  1: values A-F drawn as hex; 0: values 10-15 drawn as minus
blank_lz_in  input  1  1: blank leading zeros
glyph_seg_out  output  7  {g,f,e,d,c,b,a} for current digit
glyph_x_out  output  5  column index within glyph, 0..GLYPH_W-1
glyph_y_out  output  3  page index, 0..PAGES-1
glyph_pixels_in  input  8  pixel byte for (glyph_seg_out, glyph_x_out, glyph_y_out), same cycle
data_out  output  8  column byte, LSB = top pixel
valid_out  output  1  data_out valid
ready_in  input  1  consumer ready
page_start_out  output  1  qualifies data_out as first byte of a page
busy_out  output  1  render in progress
done_out  output  1  one-cycle pulse after final byte handshake

Behaviour:
- Reset (asynchronous, reset_n_in low): all outputs 0, state IDLE, cursors 0, latched digits/modes 0. Reset mid-stream aborts; no done_out is produced.
- FSM states:
  - IDLE: start_in=1 at an edge latches digits_in, hex_mode_in and blank_lz_in; sets busy_out=1; clears cursors (page, digit, col); goes to STREAM.
  - STREAM: runs until the last byte is handshaken, then goes to DONE.
  - DONE: done_out=1 for exactly one cycle, busy_out=0, returns to IDLE.
- start_in is ignored while busy_out=1. A start in the DONE cycle is also ignored.
- Traversal order: page-major. For page 0..PAGES-1, for digit 0..DIGITS-1, for col 0..GLYPH_W+GAP_W-1.
  - Total bytes per render = PAGES*DIGITS*(GLYPH_W+GAP_W).
  - col wraps to 0 and advances digit; digit wraps and advances page.
- Output register:
  - Loads when state=STREAM, the cursor is not exhausted, and (valid_out=0 or ready_in=1). The cursor advances on each load.
  - Load value: glyph_pixels_in if col<GLYPH_W; 8'h00 for gap columns (glyph lookup ignored).
  - page_start_out is loaded as 1 when digit=0 and col=0.
  - valid_out clears on a handshake when nothing is loaded.
  - First valid_out=1 appears after the edge following the start edge.
  - Full throughput is one byte per cycle when ready_in is held high.
  - data_out, valid_out and page_start_out are stable while valid_out=1 and ready_in=0.
- Glyph index outputs are combinational from the cursor:
  - glyph_x_out = col, or 0 in gap columns.
  - glyph_y_out = page.
  - glyph_seg_out = decoded segments of the latched digit at cursor.digit.
- Segment decode:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - Values 10-15 give 40 (minus) when hex_mode=0.
- Leading-zero blanking (blank_lz=1): digit i decodes to 00 if all digits 0..i are zero and i<DIGITS-1. The rightmost digit is never blanked.
- Last-byte handshake (valid_out & ready_in, cursor exhausted) moves the FSM to DONE on the same edge.

Test Plan:
- DIGITS=6, GLYPH_W=21, GAP_W=3, PAGES=4, ready_in=1, start with digits 0x123456 -> exactly 576 bytes on consecutive cycles. page_start_out set on bytes 0, 144, 288, 432. done_out pulses once, the cycle after byte 575. busy_out high throughout.
- Same render with blank_lz=1 and digits 0x000070 -> glyph_seg_out=00 for digits 0..3, 07 for digit 4, 3F for digit 5. Gap-column bytes (col 21..23) all 00 regardless of glyph_pixels_in.
- hex_mode=0, digits 0xABCDEF -> glyph_seg_out=40 for every digit. With hex_mode=1 -> 77,7C,39,5E,79,71.
- Random ready_in backpressure (~50%) -> byte sequence identical to the ready_in=1 run. data_out is never altered while valid_out=1 and ready_in=0. No byte is dropped or duplicated.
- start_in pulsed at byte 100 of a render, with different digits_in -> ignored. The stream completes unchanged with a single done_out.
- reset_n_in asserted at byte 200 -> valid_out, busy_out and done_out drop to 0 immediately (asynchronously). After release, a new start renders from page 0, col 0.

Source files
------------

// File: rtl/seg7_row_streamer.sv
// Seven-segment row renderer. It walks the page, digit and column cursors and
// streams SSD1306 page-mode column bytes under valid/ready flow control.
module seg7_row_streamer #(
    parameter int unsigned DIGITS  = 6,
    parameter int unsigned GLYPH_W = 21,
    parameter int unsigned GAP_W   = 3,
    parameter int unsigned PAGES   = 4
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    input  logic                start_in,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic                hex_mode_in,
    input  logic                blank_lz_in,
    output logic [6:0]          glyph_seg_out,
    output logic [4:0]          glyph_x_out,
    output logic [2:0]          glyph_y_out,
    input  logic [7:0]          glyph_pixels_in,
    output logic [7:0]          data_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                page_start_out,
    output logic                busy_out,
    output logic                done_out
);

    localparam logic [5:0] COL_LAST   = 6'(GLYPH_W + GAP_W - 1);
    localparam logic [5:0] COL_GLYPH  = 6'(GLYPH_W);
    localparam logic [3:0] DIGIT_LAST = 4'(DIGITS - 1);
    localparam logic [2:0] PAGE_LAST  = 3'(PAGES - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] digits_q;
    logic                hex_q, blank_q;
    logic [2:0]          page_q;
    logic [3:0]          digit_q;
    logic [5:0]          col_q;
    logic                exhausted_q;
    logic [7:0]          data_q;
    logic                valid_q, page_start_q;

    logic       accept, load, handshake, last_pos, in_gap;
    logic [3:0] cur_val;
    logic       cur_blank, zero_run;
    logic [6:0] seg_raw;

    always_comb begin
        accept    = (state_q == StIdle) && start_in;
        load      = (state_q == StStream) && !exhausted_q && (!valid_q || ready_in);
        handshake = valid_q && ready_in;
        last_pos  = (page_q == PAGE_LAST) && (digit_q == DIGIT_LAST) && (col_q == COL_LAST);
        in_gap    = (col_q >= COL_GLYPH);

        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_in) state_d = StStream;
            StStream: if (exhausted_q && handshake) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // zero_run tracks "every digit from the left up to i is zero".
    always_comb begin
        cur_val   = 4'h0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            zero_run = zero_run & (digits_q[4*(DIGITS-i)-1 -: 4] == 4'h0);
            if (digit_q == 4'(i)) begin
                cur_val   = digits_q[4*(DIGITS-i)-1 -: 4];
                cur_blank = blank_q & zero_run & (i < DIGITS - 1);
            end
        end

        case (cur_val)
            4'h0:    seg_raw = 7'h3F;
            4'h1:    seg_raw = 7'h06;
            4'h2:    seg_raw = 7'h5B;
            4'h3:    seg_raw = 7'h4F;
            4'h4:    seg_raw = 7'h66;
            4'h5:    seg_raw = 7'h6D;
            4'h6:    seg_raw = 7'h7D;
            4'h7:    seg_raw = 7'h07;
            4'h8:    seg_raw = 7'h7F;
            4'h9:    seg_raw = 7'h6F;
            4'hA:    seg_raw = 7'h77;
            4'hB:    seg_raw = 7'h7C;
            4'hC:    seg_raw = 7'h39;
            4'hD:    seg_raw = 7'h5E;
            4'hE:    seg_raw = 7'h79;
            default: seg_raw = 7'h71;
        endcase
        if (!hex_q && (cur_val >= 4'd10)) seg_raw = 7'h40;

        glyph_seg_out = ((state_q != StStream) || cur_blank) ? 7'h00 : seg_raw;
        glyph_x_out   = in_gap ? 5'd0 : col_q[4:0];
        glyph_y_out   = page_q;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= StIdle;
            digits_q     <= '0;
            hex_q        <= 1'b0;
            blank_q      <= 1'b0;
            page_q       <= 3'd0;
            digit_q      <= 4'd0;
            col_q        <= 6'd0;
            exhausted_q  <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            page_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                digits_q    <= digits_in;
                hex_q       <= hex_mode_in;
                blank_q     <= blank_lz_in;
                page_q      <= 3'd0;
                digit_q     <= 4'd0;
                col_q       <= 6'd0;
                exhausted_q <= 1'b0;
            end
            if (load) begin
                data_q       <= in_gap ? 8'h00 : glyph_pixels_in;
                valid_q      <= 1'b1;
                page_start_q <= (digit_q == 4'd0) && (col_q == 6'd0);
                if (last_pos) exhausted_q <= 1'b1;
                if (col_q == COL_LAST) begin
                    col_q <= 6'd0;
                    if (digit_q == DIGIT_LAST) begin
                        digit_q <= 4'd0;
                        page_q  <= (page_q == PAGE_LAST) ? 3'd0 : page_q + 3'd1;
                    end else begin
                        digit_q <= digit_q + 4'd1;
                    end
                end else begin
                    col_q <= col_q + 6'd1;
                end
            end else if (handshake) begin
                valid_q      <= 1'b0;
                page_start_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out       = data_q;
        valid_out      = valid_q;
        page_start_out = page_start_q;
        busy_out       = (state_q == StStream);
        done_out       = (state_q == StDone);
    end

endmodule

// File: tb/tb_seg7_row_streamer.sv
// Randomized scoreboard bench for seg7_row_streamer with a spec-level reference model
// and a pixel lookup whose output is unique per segment pattern and never zero.
module tb_seg7_row_streamer;

    localparam int DIGITS  = 6;
    localparam int GLYPH_W = 21;
    localparam int GAP_W   = 3;
    localparam int PAGES   = 4;
    localparam int COLS    = GLYPH_W + GAP_W;
    localparam int TOTAL   = PAGES * DIGITS * COLS;
    localparam int BOUND   = 20000;

    localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
        7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic                clk = 1'b0;
    logic                reset_n_in;
    logic                start_in;
    logic [4*DIGITS-1:0] digits_in;
    logic                hex_mode_in, blank_lz_in;
    logic [6:0]          glyph_seg_out;
    logic [4:0]          glyph_x_out;
    logic [2:0]          glyph_y_out;
    logic [7:0]          glyph_pixels_in;
    logic [7:0]          data_out;
    logic                valid_out, ready_in, page_start_out, busy_out, done_out;

    int n_vec = 0;
    int n_err = 0;
    int bytes_seen = 0;
    int done_count = 0;
    int cyc = 0;
    int last_hs_cyc = -10;
    logic [8:0] exp_q [$];

    seg7_row_streamer #(
        .DIGITS (DIGITS),
        .GLYPH_W(GLYPH_W),
        .GAP_W  (GAP_W),
        .PAGES  (PAGES)
    ) dut (
        .clk_in         (clk),
        .reset_n_in     (reset_n_in),
        .start_in       (start_in),
        .digits_in      (digits_in),
        .hex_mode_in    (hex_mode_in),
        .blank_lz_in    (blank_lz_in),
        .glyph_seg_out  (glyph_seg_out),
        .glyph_x_out    (glyph_x_out),
        .glyph_y_out    (glyph_y_out),
        .glyph_pixels_in(glyph_pixels_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .page_start_out (page_start_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk = ~clk;

    // Bit 7 is always set so glyph bytes can never be confused with gap bytes.
    function automatic logic [7:0] pix(input logic [6:0] s, input int x, input int y);
        logic [6:0] mix;
        mix = 7'((x * 5 + y * 19) & 127);
        return {1'b1, s ^ mix};
    endfunction

    assign glyph_pixels_in = pix(glyph_seg_out, int'(glyph_x_out), int'(glyph_y_out));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_expected(input logic [4*DIGITS-1:0] d, input bit hex, input bit blank);
        int vals [DIGITS];
        for (int i = 0; i < DIGITS; i++) vals[i] = int'((d >> (4 * (DIGITS - 1 - i))) & 15);
        for (int p = 0; p < PAGES; p++) begin
            for (int di = 0; di < DIGITS; di++) begin
                bit         all_zero;
                logic [6:0] seg;
                all_zero = 1;
                for (int k = 0; k <= di; k++) if (vals[k] != 0) all_zero = 0;
                if (blank && all_zero && di < DIGITS - 1) seg = 7'h00;
                else if (!hex && vals[di] >= 10) seg = 7'h40;
                else seg = SEG_TBL[vals[di]];
                for (int c = 0; c < COLS; c++) begin
                    logic [7:0] b;
                    b = (c < GLYPH_W) ? pix(seg, c, p) : 8'h00;
                    exp_q.push_back({(di == 0 && c == 0), b});
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and guards stall stability.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out;
    always @(negedge clk) begin
        cyc++;
        if (!reset_n_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", valid_out, 1);
                check("stall_data", {page_start_out, data_out}, prev_out);
            end
            if (valid_out) check("busy_while_valid", busy_out, 1);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d_data", bytes_seen), data_out, e[7:0]);
                    check($sformatf("byte%0d_page_start", bytes_seen), page_start_out, e[8]);
                end
                bytes_seen++;
                last_hs_cyc = cyc;
            end
            if (done_out) begin
                check("done_after_last_byte", cyc - last_hs_cyc, 1);
                check("done_queue_empty", exp_q.size(), 0);
                done_count++;
            end
            prev_stall = valid_out && !ready_in;
            prev_out   = {page_start_out, data_out};
        end
    end

    // special: 0 none, 1 start pulse at byte 100, 2 reset at byte 200, 3 start in DONE cycle
    task automatic render(input logic [4*DIGITS-1:0] d, input bit hex, input bit blank,
                          input bit rnd_ready, input int special);
        int n, base_bytes, base_done;
        bit got_done, pulsed;
        n = 0;
        got_done = 0;
        pulsed = 0;
        base_bytes = bytes_seen;
        base_done = done_count;
        push_expected(d, hex, blank);
        digits_in   = d;
        hex_mode_in = hex;
        blank_lz_in = blank;
        start_in    = 1'b1;
        @(posedge clk);
        #1;
        start_in    = 1'b0;
        digits_in   = 24'($urandom);
        hex_mode_in = ~hex;
        blank_lz_in = ~blank;
        while (!got_done && n < BOUND) begin
            ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (special == 1 && !pulsed && bytes_seen - base_bytes >= 100) begin
                start_in  = 1'b1;
                digits_in = 24'h987654;
                pulsed    = 1;
            end else begin
                start_in = 1'b0;
            end
            if (special == 2 && bytes_seen - base_bytes >= 200) begin
                reset_n_in = 1'b0;
                #1;
                check("reset_valid", valid_out, 0);
                check("reset_busy", busy_out, 0);
                check("reset_done", done_out, 0);
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                reset_n_in = 1'b1;
                check("post_reset_busy", busy_out, 0);
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (done_out) got_done = 1;
            else check("busy_during_render", busy_out, 1);
        end
        start_in = 1'b0;
        if (special != 2) begin
            check("done_seen", got_done, 1);
            if (!rnd_ready) check("full_throughput_cycles", n, TOTAL + 1);
            check("render_bytes", bytes_seen - base_bytes, TOTAL);
            if (special == 3) begin
                start_in  = 1'b1;
                digits_in = 24'h111111;
                @(posedge clk);
                #1;
                start_in = 1'b0;
                check("start_in_done_ignored", busy_out, 0);
            end
        end
        ready_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("done_pulse_count", done_count - base_done, (special == 2) ? 0 : 1);
        check("render_queue_drained", exp_q.size(), 0);
        check("idle_after_render", busy_out, 0);
    endtask

    initial begin
        reset_n_in  = 1'b0;
        start_in    = 1'b0;
        digits_in   = '0;
        hex_mode_in = 1'b0;
        blank_lz_in = 1'b0;
        ready_in    = 1'b1;
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_data", data_out, 0);
        check("rst_page_start", page_start_out, 0);
        check("rst_seg", glyph_seg_out, 0);
        check("rst_xy", {glyph_x_out, glyph_y_out}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n_in = 1'b1;
        @(posedge clk);
        #1;

        render(24'h123456, 1'b1, 1'b0, 1'b0, 3);
        render(24'h000070, 1'b1, 1'b1, 1'b0, 0);
        render(24'hABCDEF, 1'b0, 1'b0, 1'b0, 0);
        render(24'hABCDEF, 1'b1, 1'b0, 1'b0, 0);
        render(24'h123456, 1'b1, 1'b0, 1'b1, 0);
        render(24'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1);
        render(24'($urandom), 1'($urandom), 1'($urandom), 1'b1, 2);
        render(24'h000000, 1'b1, 1'b1, 1'b1, 0);
        render(24'h00F0A1, 1'b0, 1'b1, 1'b1, 0);
        render(24'($urandom), 1'($urandom), 1'($urandom), 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
